// File: rtl/posterior_state_serial.sv
// Serial Kalman measurement update: innovation plus 2-state posterior.
// Two shared multipliers and one 2N adder, sequenced by a 6-state FSM.
module posterior_state_serial #(
  parameter int N    = 16,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x_prior00,
  input  logic [N-1:0] x_prior10,
  input  logic [N-1:0] h00,
  input  logic [N-1:0] h01,
  input  logic [N-1:0] z,
  input  logic [N-1:0] k00,
  input  logic [N-1:0] k10,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Y_INNOV,
  output logic [N-1:0] X_POST00,
  output logic [N-1:0] X_POST10
);

  localparam int unsigned W2 = 2 * N;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HX   = 3'd1;
  localparam logic [2:0] ST_INN  = 3'd2;
  localparam logic [2:0] ST_KY   = 3'd3;
  localparam logic [2:0] ST_UP0  = 3'd4;
  localparam logic [2:0] ST_UP1  = 3'd5;

  logic [2:0]    st, st_nxt;
  logic [N-1:0]  xp00_q, xp10_q, z_q, k00_q, k10_q;
  logic [N-1:0]  m0a, m0b, m1a, m1b;
  logic [W2-1:0] hx_q, ky0_q, ky1_q;

  logic signed [W2-1:0] m0a_x, m0b_x, m1a_x, m1b_x;
  logic signed [W2-1:0] p0, p1;
  logic [W2-1:0] z_sh, xp00_sh, xp10_sh;
  logic [W2-1:0] add_a, add_b, sum;
  logic          add_ci;
  logic [N-1:0]  aligned;
  logic          sum_unused;

  // Shared multipliers: operands sign-extended so the 2N result is exact
  assign m0a_x = {{N{m0a[N-1]}}, m0a};
  assign m0b_x = {{N{m0b[N-1]}}, m0b};
  assign m1a_x = {{N{m1a[N-1]}}, m1a};
  assign m1b_x = {{N{m1b[N-1]}}, m1b};
  assign p0    = m0a_x * m0b_x;
  assign p1    = m1a_x * m1b_x;

  assign z_sh    = {{(N-FRAC){z_q[N-1]}}, z_q, {FRAC{1'b0}}};
  assign xp00_sh = {{(N-FRAC){xp00_q[N-1]}}, xp00_q, {FRAC{1'b0}}};
  assign xp10_sh = {{(N-FRAC){xp10_q[N-1]}}, xp10_q, {FRAC{1'b0}}};

  // Single adder; subtraction is a + ~b + 1 through the carry-in
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    case (st)
      ST_HX:  begin add_a = p0;      add_b = p1;      end
      ST_INN: begin add_a = z_sh;    add_b = ~hx_q;   add_ci = 1'b1; end
      ST_UP0: begin add_a = xp00_sh; add_b = ky0_q;   end
      ST_UP1: begin add_a = xp10_sh; add_b = ky1_q;   end
      default: ;
    endcase
  end

  assign sum        = add_a + add_b + W2'(add_ci);
  assign aligned    = sum[FRAC+N-1:FRAC];
  assign sum_unused = ^{sum[W2-1:FRAC+N], sum[FRAC-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = ST_IDLE;
    case (st)
      ST_IDLE: st_nxt = start ? ST_HX : ST_IDLE;
      ST_HX:   st_nxt = ST_INN;
      ST_INN:  st_nxt = ST_KY;
      ST_KY:   st_nxt = ST_UP0;
      ST_UP0:  st_nxt = ST_UP1;
      ST_UP1:  st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xp00_q   <= '0;
      xp10_q   <= '0;
      z_q      <= '0;
      k00_q    <= '0;
      k10_q    <= '0;
      m0a      <= '0;
      m0b      <= '0;
      m1a      <= '0;
      m1b      <= '0;
      hx_q     <= '0;
      ky0_q    <= '0;
      ky1_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Y_INNOV  <= '0;
      X_POST00 <= '0;
      X_POST10 <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (start) begin
            xp00_q <= x_prior00;
            xp10_q <= x_prior10;
            z_q    <= z;
            k00_q  <= k00;
            k10_q  <= k10;
            m0a    <= h00;
            m0b    <= x_prior00;
            m1a    <= h01;
            m1b    <= x_prior10;
            busy   <= 1'b1;
          end
        end
        ST_HX: hx_q <= sum;
        ST_INN: begin
          Y_INNOV <= aligned;
          m0a     <= k00_q;
          m0b     <= aligned;
          m1a     <= k10_q;
          m1b     <= aligned;
        end
        ST_KY: begin
          ky0_q <= p0;
          ky1_q <= p1;
          m0a   <= '0;
          m0b   <= '0;
          m1a   <= '0;
          m1b   <= '0;
        end
        ST_UP0: X_POST00 <= aligned;
        ST_UP1: begin
          X_POST10 <= aligned;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_posterior_state_serial.sv
// Directed bench for posterior_state_serial with an expected-result scoreboard.
module tb_posterior_state_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] x_prior00, x_prior10, h00, h01, z, k00, k10;
  logic        busy, done;
  logic [15:0] Y_INNOV, X_POST00, X_POST10;

  typedef struct {
    logic [15:0] y;
    logic [15:0] x0;
    logic [15:0] x1;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  posterior_state_serial #(.N(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_prior00(x_prior00), .x_prior10(x_prior10),
    .h00(h00), .h01(h01), .z(z), .k00(k00), .k10(k10),
    .busy(busy), .done(done),
    .Y_INNOV(Y_INNOV), .X_POST00(X_POST00), .X_POST10(X_POST10)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Reference model of the fixed-point update (Q8.8, 32-bit wrap, floor)
  function automatic exp_t model(input logic [15:0] xp0, xp1, hh0, hh1, zz, kk0, kk1);
    exp_t m;
    logic signed [31:0] hx, t;
    hx   = sx(hh0) * sx(xp0) + sx(hh1) * sx(xp1);
    t    = (sx(zz) <<< 8) - hx;
    m.y  = t[23:8];
    t    = (sx(xp0) <<< 8) + sx(kk0) * sx(m.y);
    m.x0 = t[23:8];
    t    = (sx(xp1) <<< 8) + sx(kk1) * sx(m.y);
    m.x1 = t[23:8];
    m.due = 0;
    return m;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending request on time
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      exp_t e;
      done_cnt++;
      chk("done_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("done_latency", 32'(cyc), 32'(e.due));
        chk("Y_INNOV", 32'(Y_INNOV), 32'(e.y));
        chk("X_POST00", 32'(X_POST00), 32'(e.x0));
        chk("X_POST10", 32'(X_POST10), 32'(e.x1));
        chk("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic set_in(input logic [15:0] xp0, xp1, hh0, hh1, zz, kk0, kk1);
    x_prior00 = xp0; x_prior10 = xp1; h00 = hh0; h01 = hh1;
    z = zz; k00 = kk0; k10 = kk1;
  endtask

  // Called at a negedge while idle: the next posedge accepts
  task automatic push_exp(input logic [15:0] y, x0, x1);
    exp_t e;
    e.y = y; e.x0 = x0; e.x1 = x1; e.due = cyc + 6;
    q.push_back(e);
  endtask

  task automatic run_op(input logic [15:0] xp0, xp1, hh0, hh1, zz, kk0, kk1,
                        input logic [15:0] y, x0, x1);
    @(negedge clk);
    set_in(xp0, xp1, hh0, hh1, zz, kk0, kk1);
    start = 1'b1;
    push_exp(y, x0, x1);
    @(negedge clk);
    start = 1'b0;
    set_in($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    exp_t m;
    int dc;
    rst_n = 1'b0;
    start = 1'b0;
    set_in(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_y", 32'(Y_INNOV), 32'd0);
    chk("rst_x00", 32'(X_POST00), 32'd0);
    chk("rst_x10", 32'(X_POST10), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic update with busy profile and an ignored start while busy
    @(negedge clk);
    set_in(16'h0100, 16'h0200, 16'h0100, 16'h0000, 16'h0180, 16'h0080, 16'h0040);
    start = 1'b1;
    push_exp(16'h0080, 16'h0140, 16'h0220);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = (i == 2);
      if (i == 2) set_in(16'h1234, 16'h4321, 16'h0300, 16'h0300, 16'h7000, 16'h0100, 16'h0100);
      chk("busy_inflight", 32'(busy), 32'd1);
      chk("no_early_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("done_at_6", 32'(done), 32'd1);
    drain();
    repeat (8) @(negedge clk);
    chk("no_queued_start", 32'(busy), 32'd0);

    // Signed values
    run_op(16'hFF00, 16'h0080, 16'h0080, 16'h0080, 16'h0000, 16'h0100, 16'hFF00,
           16'h0040, 16'hFF40, 16'h0040);
    drain();
    // Floor truncation, negative and positive
    run_op(16'h0, 16'h0, 16'h0, 16'h0, 16'hFF80, 16'h0001, 16'h0001,
           16'hFF80, 16'hFFFF, 16'hFFFF);
    drain();
    run_op(16'h0, 16'h0, 16'h0, 16'h0, 16'h0080, 16'h0001, 16'h0001,
           16'h0080, 16'h0000, 16'h0000);
    drain();
    // Wrap without saturation
    run_op(16'h7F00, 16'h0, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0,
           16'h0200, 16'h7F00, 16'h0000);
    drain();

    // start held high: accepts every 6 cycles, inputs scrambled after capture
    dc = done_cnt;
    @(negedge clk);
    start = 1'b1;
    for (int op = 0; op < 4; op++) begin
      set_in($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      m = model(x_prior00, x_prior10, h00, h01, z, k00, k10);
      push_exp(m.y, m.x0, m.x1);
      @(negedge clk);
      set_in($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      repeat (5) @(negedge clk);
    end
    start = 1'b0;
    drain();
    chk("b2b_done_count", 32'(done_cnt - dc), 32'd4);

    // Asynchronous reset during KY aborts the operation
    dc = done_cnt;
    run_op(16'h0100, 16'h0200, 16'h0100, 16'h0000, 16'h0180, 16'h0080, 16'h0040,
           16'h0080, 16'h0140, 16'h0220);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_y", 32'(Y_INNOV), 32'd0);
    chk("arst_x00", 32'(X_POST00), 32'd0);
    chk("arst_x10", 32'(X_POST10), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_done_after_abort", 32'(done_cnt - dc), 32'd0);
    m = model(16'hFF00, 16'h0080, 16'h0080, 16'h0080, 16'h0000, 16'h0100, 16'hFF00);
    run_op(16'hFF00, 16'h0080, 16'h0080, 16'h0080, 16'h0000, 16'h0100, 16'hFF00,
           m.y, m.x0, m.x1);
    drain();
    chk("post_reset_done_count", 32'(done_cnt - dc), 32'd1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
